// File: rtl/sync_updown_counter_if.sv
// rtl/sync_updown_counter_if.sv - control/status bundle for the synchronous up/down counter
interface sync_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up_dn, clr, load, d,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  en, up_dn, clr, load, d,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/sync_updown_counter.sv
// rtl/sync_updown_counter.sv - parametrised modulo-N synchronous up/down counter with wrap/saturate
module sync_updown_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MOD      = 16,
  parameter int              SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_updown_counter_if.slave  bus
);

  // The modulus may equal 2^WIDTH, so the top value is formed one bit wider before being narrowed.
  localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] TOP     = TOP_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             ovf_r;
  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] load_val;

  assign at_top  = (q_r == TOP);
  assign at_zero = (q_r == '0);

  // Out-of-range load values clamp to the top of the count range.
  assign load_val = ({1'b0, bus.d} > TOP_EXT) ? TOP : bus.d;

  // Terminal count is combinational so a cascaded chain adds no latency.
  assign bus.tc = bus.en & ((bus.up_dn & at_top) | (~bus.up_dn & at_zero));

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.ovf  = ovf_r;

  // Count state: rst > clr > load > en > hold; a bound event pulses wrap and sets sticky ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (bus.clr) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (bus.load) begin
      q_r    <= load_val;
      wrap_r <= 1'b0;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_top) begin
          q_r    <= (SATURATE != 0) ? TOP : '0;
          wrap_r <= 1'b1;
          ovf_r  <= 1'b1;
        end else begin
          q_r    <= q_r + ONE;
          wrap_r <= 1'b0;
        end
      end else begin
        if (at_zero) begin
          q_r    <= (SATURATE != 0) ? '0 : TOP;
          wrap_r <= 1'b1;
          ovf_r  <= 1'b1;
        end else begin
          q_r    <= q_r - ONE;
          wrap_r <= 1'b0;
        end
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

endmodule
